axis_packetizer: RTL and testbench
==================================

# axis_packetizer

Downstream stage for the AXI-Stream register slice. It consumes the slice's untagged data stream and cuts it into packets by asserting `m_axis_tlast` on the last beat of each run of `pkt_len` beats. It also supports an early-close `flush`. The output is fully registered through a two-entry skid buffer, so timing stays broken toward the DMA/packet sink and throughput is one beat per cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, tdata width in bits
- LEN_WIDTH, 16, width of packet-length input and beat counter

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- pkt_len  in  LEN_WIDTH  beats per packet; sampled on first beat of each packet; 0 treated as 1
- flush  in  1  when high with an accepted input beat, that beat closes the packet
- s_axis_tvalid  in  1  upstream beat valid
- s_axis_tdata  in  DATA_WIDTH  upstream data
- s_axis_tready  out  1  registered ready to upstream
- m_axis_tvalid  out  1  output beat valid
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tlast  out  1  last beat of packet
- m_axis_tready  in  1  downstream ready
- pkt_count  out  32  packets fully delivered (tlast handshakes); wraps 2^32-1 -> 0

## Operation
- Accept: s_axis_tvalid && s_axis_tready. Deliver: m_axis_tvalid && m_axis_tready.
- beat_cnt (LEN_WIDTH): 0 at packet start. len_reg latches max(pkt_len,1) when a beat is accepted with beat_cnt==0.
- eff_len = (beat_cnt==0) ? max(pkt_len,1) : len_reg. pkt_len changes mid-packet have no effect.
- Accepted beat's tlast = (beat_cnt == eff_len-1) || flush. If tlast, beat_cnt <= 0; else beat_cnt+1.
- flush without an accepted beat is ignored (no empty packets, no state change).
- Skid buffer holds main (drives m_axis_*) and skid {tdata,tlast}. States:
  - EMPTY: m_axis_tvalid=0. Accept -> main, go ONE.
  - ONE: accept and deliver -> main reloaded, stay ONE. Accept only -> skid, go FULL. Deliver only -> EMPTY.
  - FULL: s_axis_tready=0. Deliver -> skid moves to main, go ONE.
- s_axis_tready is a flop: next = (next_state != FULL). Must never combinationally depend on m_axis_tready.
- pkt_count increments on every deliver with m_axis_tlast=1.
- Data and tlast pass unmodified; beat order is preserved; no beat is dropped or duplicated.

## Timing
- Reset values (asynchronous, held while reset=1):
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, pkt_count=0
  - beat_cnt=0, len_reg=1, state EMPTY
- First rising edge after reset deassertion: s_axis_tready=1.
- Latency: beat accepted at edge N appears on m_axis_* after edge N (valid cycle N+1) if EMPTY or delivering.
- Throughput: 1 beat/cycle sustained while m_axis_tready=1.
- Backpressure: m_axis_tready low from ONE with input active → one more beat lands in skid, then s_axis_tready drops the following cycle.
- While m_axis_tvalid=1 and not delivered, m_axis_tdata/m_axis_tlast stay stable.
- Reset mid-packet: buffered beats discarded, beat_cnt=0. The next accepted beat starts a new packet.
- pkt_len=1: every beat has tlast. pkt_len=2^LEN_WIDTH-1: beat_cnt reaches max-1, no overflow.

## Test plan
- pkt_len=4, 12 beats 0..11 streaming, m_axis_tready=1 -> tlast on data 3,7,11; one beat/cycle; pkt_count=3.
- pkt_len=3, flush with beat 1 -> tlast on beat 1. Next packet restarts at beat 2 with tlast on beat 4. flush with no valid input -> no change.
- Continuous input, m_axis_tready toggles 1,0,0,1 -> s_axis_tready drops one cycle after first stall. Outputs stable while stalled; sequence intact, no loss/duplication.
- pkt_len=0 and pkt_len=1 -> every beat tlast. pkt_len changed 5->2 mid-packet -> current packet still 5 beats, next packet 2.
- Reset asserted asynchronously while FULL mid-packet -> all outputs zero immediately. After release, 2-beat packet (pkt_len=2) delivered correctly, pkt_count=1.
- pkt_count preloaded near wrap via 2^32-1 short packets (or forced) -> next tlast handshake wraps to 0.

Source files
------------

// File: rtl/axis_packetizer_if.sv
// Stream bundle shared by the packetizer's input and output sides.
// Latency: none, wires only.
// Backpressure: tready flows opposite to tvalid/tdata/tlast.
//
// Signals:
//   tvalid : beat valid
//   tready : sink can take the beat
//   tdata  : beat payload
//   tlast  : last beat of a packet (output side only)
//
// The slave modport has no tlast because the upstream stream is untagged.
interface axis_packetizer_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_packetizer.sv
// Cuts an untagged stream into packets of pkt_len beats (or earlier on flush).
// Latency: 1 cycle, input edge to m_axis valid, through a registered two-entry skid buffer.
// Backpressure: s_axis.tready is a flop that drops only once the skid entry is occupied.
//
// Ports:
//   clk, reset : rising-edge clock; asynchronous active-high reset
//   pkt_len    : beats per packet, sampled on the first beat (0 acts as 1)
//   flush      : closes the packet on the beat accepted with it
//   s_axis     : upstream stream (tvalid/tdata in, tready out)
//   m_axis     : downstream stream (tvalid/tdata/tlast out, tready in)
//   pkt_count  : count of tlast handshakes delivered, wraps at 2^32
module axis_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LEN_WIDTH-1:0]   pkt_len,
  input  logic                   flush,
  axis_packetizer_if.slave       s_axis,
  axis_packetizer_if.master      m_axis,
  output logic [31:0]            pkt_count
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_s_rdy;
  logic [DATA_WIDTH-1:0] r_main_dat;
  logic                  r_main_last;
  logic [DATA_WIDTH-1:0] r_skid_dat;
  logic                  r_skid_last;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [31:0]           r_pkt_count;

  logic                  w_acc;
  logic                  w_dlv;
  logic                  w_beat_last;
  logic                  w_load_main;
  logic                  w_load_skid;
  logic                  w_skid_to_main;
  logic [LEN_WIDTH-1:0]  w_len_in;
  logic [LEN_WIDTH-1:0]  w_eff_len;

  assign w_acc = s_axis.tvalid & r_s_rdy;
  assign w_dlv = (r_state != ST_EMPTY) & m_axis.tready;

  // The first beat of a packet uses the live pkt_len; later beats use the
  // value latched with that first beat, so mid-packet changes are ignored.
  assign w_len_in    = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
  assign w_eff_len   = (r_beat_cnt == '0) ? w_len_in : r_len;
  assign w_beat_last = (r_beat_cnt == (w_eff_len - LEN_WIDTH'(1))) | flush;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_load_main = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_acc && w_dlv) begin
          w_load_main = 1'b1;
        end else if (w_acc) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_dlv) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // tready is low here, so only the drain side can move.
        if (w_dlv) begin
          w_skid_to_main = 1'b1;
          w_state_nxt    = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Ready is computed from the next state, so it never sees m_axis.tready
  // combinationally and drops exactly when the skid entry fills.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_s_rdy <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s_rdy <= (w_state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_dat  <= '0;
      r_main_last <= 1'b0;
      r_skid_dat  <= '0;
      r_skid_last <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_dat  <= s_axis.tdata;
        r_main_last <= w_beat_last;
      end else if (w_skid_to_main) begin
        r_main_dat  <= r_skid_dat;
        r_main_last <= r_skid_last;
      end
      if (w_load_skid) begin
        r_skid_dat  <= s_axis.tdata;
        r_skid_last <= w_beat_last;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat_cnt <= '0;
      r_len      <= LEN_WIDTH'(1);
    end else if (w_acc) begin
      if (r_beat_cnt == '0) begin
        r_len <= w_len_in;
      end
      r_beat_cnt <= w_beat_last ? '0 : (r_beat_cnt + LEN_WIDTH'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_count <= '0;
    end else if (w_dlv && r_main_last) begin
      r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  assign s_axis.tready = r_s_rdy;
  assign m_axis.tvalid = (r_state != ST_EMPTY);
  assign m_axis.tdata  = r_main_dat;
  assign m_axis.tlast  = r_main_last;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed vector bench for axis_packetizer.
// Each step drives inputs, checks outputs produced by earlier edges, then clocks once.
// Backpressure, flush, length-change, reset and wrap corners are covered by directed rows.
module tb_axis_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pkt_len = 16'd0;
  logic        flush = 1'b0;
  logic [31:0] pkt_count;

  axis_packetizer_if #(.DATA_WIDTH(32)) s_if ();
  axis_packetizer_if #(.DATA_WIDTH(32)) m_if ();

  axis_packetizer #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_len   (pkt_len),
    .flush     (flush),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s_vld;
    logic [31:0] s_dat;
    logic        fl;
    logic [15:0] len;
    logic        m_rdy;
    logic        e_srdy;
    logic        e_mvld;
    logic [31:0] e_dat;
    logic        e_last;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t v(input logic s_vld, input logic [31:0] s_dat,
                             input logic fl, input logic [15:0] len,
                             input logic m_rdy, input logic e_srdy,
                             input logic e_mvld, input logic [31:0] e_dat,
                             input logic e_last);
    vec_t r;
    r.s_vld = s_vld; r.s_dat = s_dat; r.fl = fl; r.len = len; r.m_rdy = m_rdy;
    r.e_srdy = e_srdy; r.e_mvld = e_mvld; r.e_dat = e_dat; r.e_last = e_last;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  // Drive one row, check the current outputs, then advance one clock.
  task automatic step(input vec_t x, input int idx);
    s_if.tvalid  = x.s_vld;
    s_if.tdata   = x.s_dat;
    flush        = x.fl;
    pkt_len      = x.len;
    m_if.tready  = x.m_rdy;
    chk("s_tready", idx, {31'd0, s_if.tready}, {31'd0, x.e_srdy});
    chk("m_tvalid", idx, {31'd0, m_if.tvalid}, {31'd0, x.e_mvld});
    if (x.e_mvld) begin
      chk("m_tdata", idx, m_if.tdata, x.e_dat);
      chk("m_tlast", idx, {31'd0, m_if.tlast}, {31'd0, x.e_last});
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    // Streaming, pkt_len=4: tlast on 3, 7, 11.
    tbl.push_back(v(1, 32'd0,  0, 4, 1, 1, 0, 32'd0,  0));
    tbl.push_back(v(1, 32'd1,  0, 4, 1, 1, 1, 32'd0,  0));
    tbl.push_back(v(1, 32'd2,  0, 4, 1, 1, 1, 32'd1,  0));
    tbl.push_back(v(1, 32'd3,  0, 4, 1, 1, 1, 32'd2,  0));
    tbl.push_back(v(1, 32'd4,  0, 4, 1, 1, 1, 32'd3,  1));
    tbl.push_back(v(1, 32'd5,  0, 4, 1, 1, 1, 32'd4,  0));
    tbl.push_back(v(1, 32'd6,  0, 4, 1, 1, 1, 32'd5,  0));
    tbl.push_back(v(1, 32'd7,  0, 4, 1, 1, 1, 32'd6,  0));
    tbl.push_back(v(1, 32'd8,  0, 4, 1, 1, 1, 32'd7,  1));
    tbl.push_back(v(1, 32'd9,  0, 4, 1, 1, 1, 32'd8,  0));
    tbl.push_back(v(1, 32'd10, 0, 4, 1, 1, 1, 32'd9,  0));
    tbl.push_back(v(1, 32'd11, 0, 4, 1, 1, 1, 32'd10, 0));
    tbl.push_back(v(0, 32'd0,  0, 4, 1, 1, 1, 32'd11, 1));
    tbl.push_back(v(0, 32'd0,  0, 4, 1, 1, 0, 32'd0,  0));
    // pkt_len=3 with flush on beat 0x21; idle flush in mid-packet is ignored.
    tbl.push_back(v(1, 32'h20, 0, 3, 1, 1, 0, 32'h00, 0));
    tbl.push_back(v(1, 32'h21, 1, 3, 1, 1, 1, 32'h20, 0));
    tbl.push_back(v(1, 32'h22, 0, 3, 1, 1, 1, 32'h21, 1));
    tbl.push_back(v(0, 32'h00, 1, 3, 1, 1, 1, 32'h22, 0));
    tbl.push_back(v(1, 32'h23, 0, 3, 1, 1, 0, 32'h00, 0));
    tbl.push_back(v(1, 32'h24, 0, 3, 1, 1, 1, 32'h23, 0));
    tbl.push_back(v(0, 32'h00, 0, 3, 1, 1, 1, 32'h24, 1));
    tbl.push_back(v(0, 32'h00, 0, 3, 1, 1, 0, 32'h00, 0));
    // pkt_len 0 and 1: every beat last; then 5 changed to 2 mid-packet.
    tbl.push_back(v(1, 32'h30, 0, 0, 1, 1, 0, 32'h00, 0));
    tbl.push_back(v(1, 32'h31, 0, 0, 1, 1, 1, 32'h30, 1));
    tbl.push_back(v(1, 32'h32, 0, 1, 1, 1, 1, 32'h31, 1));
    tbl.push_back(v(1, 32'h40, 0, 5, 1, 1, 1, 32'h32, 1));
    tbl.push_back(v(1, 32'h41, 0, 2, 1, 1, 1, 32'h40, 0));
    tbl.push_back(v(1, 32'h42, 0, 2, 1, 1, 1, 32'h41, 0));
    tbl.push_back(v(1, 32'h43, 0, 2, 1, 1, 1, 32'h42, 0));
    tbl.push_back(v(1, 32'h44, 0, 2, 1, 1, 1, 32'h43, 0));
    tbl.push_back(v(1, 32'h45, 0, 2, 1, 1, 1, 32'h44, 1));
    tbl.push_back(v(1, 32'h46, 0, 2, 1, 1, 1, 32'h45, 0));
    tbl.push_back(v(0, 32'h00, 0, 2, 1, 1, 1, 32'h46, 1));
    tbl.push_back(v(0, 32'h00, 0, 2, 1, 1, 0, 32'h00, 0));
    // Backpressure: m_ready 1,1,0,0,1... with continuous input, pkt_len=4.
    tbl.push_back(v(1, 32'h50, 0, 4, 1, 1, 0, 32'h00, 0));
    tbl.push_back(v(1, 32'h51, 0, 4, 1, 1, 1, 32'h50, 0));
    tbl.push_back(v(1, 32'h52, 0, 4, 0, 1, 1, 32'h51, 0));
    tbl.push_back(v(1, 32'h53, 0, 4, 0, 0, 1, 32'h51, 0));
    tbl.push_back(v(1, 32'h53, 0, 4, 1, 0, 1, 32'h51, 0));
    tbl.push_back(v(1, 32'h53, 0, 4, 1, 1, 1, 32'h52, 0));
    tbl.push_back(v(1, 32'h54, 0, 4, 1, 1, 1, 32'h53, 1));
    tbl.push_back(v(0, 32'h00, 0, 4, 1, 1, 1, 32'h54, 0));
    tbl.push_back(v(0, 32'h00, 0, 4, 1, 1, 0, 32'h00, 0));

    s_if.tvalid = 1'b0;
    s_if.tdata  = 32'd0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 0, {31'd0, s_if.tready}, 32'd0);
    chk("rst_m_tvalid", 0, {31'd0, m_if.tvalid}, 32'd0);
    chk("rst_m_tdata",  0, m_if.tdata, 32'd0);
    chk("rst_m_tlast",  0, {31'd0, m_if.tlast}, 32'd0);
    chk("rst_pkt_count", 0, pkt_count, 32'd0);
    reset = 1'b0;
    #1;
    chk("pre_edge_s_tready", 0, {31'd0, s_if.tready}, 32'd0);
    @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i], i);
    chk("tbl_pkt_count", 0, pkt_count, 32'd11);

    // Fill to FULL mid-packet, then reset asynchronously between edges.
    step(v(1, 32'h70, 0, 4, 0, 1, 0, 32'h00, 0), 100);
    step(v(1, 32'h71, 0, 4, 0, 1, 1, 32'h70, 0), 101);
    chk("full_s_tready", 102, {31'd0, s_if.tready}, 32'd0);
    chk("full_m_tvalid", 102, {31'd0, m_if.tvalid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_s_tready", 103, {31'd0, s_if.tready}, 32'd0);
    chk("arst_m_tvalid", 103, {31'd0, m_if.tvalid}, 32'd0);
    chk("arst_m_tdata",  103, m_if.tdata, 32'd0);
    chk("arst_m_tlast",  103, {31'd0, m_if.tlast}, 32'd0);
    chk("arst_pkt_count", 103, pkt_count, 32'd0);
    s_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(v(1, 32'h60, 0, 2, 1, 1, 0, 32'h00, 0), 110);
    step(v(1, 32'h61, 0, 2, 1, 1, 1, 32'h60, 0), 111);
    step(v(0, 32'h00, 0, 2, 1, 1, 1, 32'h61, 1), 112);
    step(v(0, 32'h00, 0, 2, 1, 1, 0, 32'h00, 0), 113);
    chk("post_rst_pkt_count", 114, pkt_count, 32'd1);

    // Counter wrap: preload all-ones, deliver one single-beat packet.
    force dut.r_pkt_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_pkt_count;
    step(v(1, 32'h80, 0, 1, 1, 1, 0, 32'h00, 0), 120);
    step(v(0, 32'h00, 0, 1, 1, 1, 1, 32'h80, 1), 121);
    step(v(0, 32'h00, 0, 1, 1, 1, 0, 32'h00, 0), 122);
    chk("wrap_pkt_count", 123, pkt_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
